// File: rtl/uart_config_negotiator.sv
// uart_config_negotiator
//   Receive-side configuration handshake for the UART controller. A run of
//   SYN_NUMBER consecutive SYN bytes opens a session. Command bytes then edit
//   a shadow copy of the line configuration. Each accepted command is answered
//   with ACK. A bad command or an inter-byte timeout is answered with NAK. The
//   end-of-configuration command commits the shadow to config_o atomically.
//
// Ports
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   rx_data_i     received byte
//   rx_valid_i    one-cycle strobe qualifying rx_data_i
//   tx_data_o     ACK/NAK byte to transmit
//   tx_valid_o    tx_data_o valid, held until tx_ready_i
//   tx_ready_i    TX path accepts the byte
//   config_o      committed configuration {stop[1:0], parity[1:0], dwidth[1:0]}
//   config_req_o  one-cycle pulse: session opened
//   config_done_o one-cycle pulse: new configuration committed
//   config_fail_o one-cycle pulse: session aborted
//   busy_o        high whenever a session is in progress
module uart_config_negotiator #(
   parameter int unsigned SYSTEM_CLOCK_FREQ = 50_000_000,
   parameter int unsigned SYN_NUMBER        = 3,
   parameter logic [7:0]  SYN_CHAR          = 8'h16,
   parameter logic [7:0]  ACK_CHAR          = 8'h06,
   parameter logic [7:0]  NAK_CHAR          = 8'h15,
   parameter int unsigned TIMEOUT_MS        = 10,
   parameter logic [5:0]  STD_CONFIGURATION = 6'b00_00_11
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   output logic [5:0] config_o,
   output logic       config_req_o,
   output logic       config_done_o,
   output logic       config_fail_o,
   output logic       busy_o
);

   localparam int unsigned TMO_CYCLES = TIMEOUT_MS * (SYSTEM_CLOCK_FREQ / 1000);
   localparam int unsigned TW         = $clog2(TIMEOUT_MS * SYSTEM_CLOCK_FREQ / 1000 + 1);
   localparam int unsigned SW         = (SYN_NUMBER > 1) ? $clog2(SYN_NUMBER) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
   localparam logic [SW-1:0] SYN_LAST = SW'(SYN_NUMBER - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_CMD,
      S_SEND_ACK,
      S_FAIL
   } state_t;

   state_t        r_state, w_next_state;
   logic [SW-1:0] r_syn_cnt, w_syn_next;
   logic [TW-1:0] r_timer, w_timer_next;
   logic [5:0]    r_config, w_config_next;
   logic [5:0]    r_shadow, w_shadow_next;
   logic          r_commit, w_commit_next;
   logic          r_req, r_done, r_fail;
   logic          w_req_next, w_done_next, w_fail_next;
   logic          w_tx_valid;
   logic [7:0]    w_tx_data;
   logic [1:0]    w_code;

   assign w_code = rx_data_i[1:0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_syn_cnt <= '0;
         r_timer   <= '0;
         r_config  <= STD_CONFIGURATION;
         r_shadow  <= STD_CONFIGURATION;
         r_commit  <= 1'b0;
         r_req     <= 1'b0;
         r_done    <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_syn_cnt <= w_syn_next;
         r_timer   <= w_timer_next;
         r_config  <= w_config_next;
         r_shadow  <= w_shadow_next;
         r_commit  <= w_commit_next;
         r_req     <= w_req_next;
         r_done    <= w_done_next;
         r_fail    <= w_fail_next;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_syn_next    = r_syn_cnt;
      w_timer_next  = r_timer;
      w_config_next = r_config;
      w_shadow_next = r_shadow;
      w_commit_next = r_commit;
      w_req_next    = 1'b0;
      w_done_next   = 1'b0;
      w_fail_next   = 1'b0;
      w_tx_valid    = 1'b0;
      w_tx_data     = '0;

      case (r_state)
         S_IDLE: begin
            if (rx_valid_i) begin
               if (rx_data_i == SYN_CHAR) begin
                  if (r_syn_cnt == SYN_LAST) begin
                     w_next_state  = S_WAIT_CMD;
                     w_syn_next    = '0;
                     w_timer_next  = '0;
                     w_shadow_next = r_config;
                     w_commit_next = 1'b0;
                     w_req_next    = 1'b1;
                  end else begin
                     w_syn_next = r_syn_cnt + 1'b1;
                  end
               end else begin
                  w_syn_next = '0;
               end
            end
         end

         S_WAIT_CMD: begin
            w_timer_next = r_timer + 1'b1;
            // A byte arriving on the last timer cycle takes priority over the timeout.
            if (rx_valid_i) begin
               w_timer_next = '0;
               // SYN is tested first: its upper nibble is nonzero and would
               // otherwise be rejected as a malformed command.
               if (rx_data_i == SYN_CHAR) begin
                  w_next_state = S_WAIT_CMD;
               end else if (rx_data_i[7:4] != 4'b0000) begin
                  w_next_state = S_FAIL;
               end else begin
                  case (rx_data_i[3:2])
                     2'b00: begin
                        w_commit_next = 1'b1;
                        w_next_state  = S_SEND_ACK;
                     end
                     2'b01: begin
                        w_shadow_next[1:0] = w_code;
                        w_next_state       = S_SEND_ACK;
                     end
                     2'b10: begin
                        w_shadow_next[3:2] = w_code;
                        w_next_state       = S_SEND_ACK;
                     end
                     default: begin
                        if (w_code[1]) begin
                           w_next_state = S_FAIL;
                        end else begin
                           w_shadow_next[5:4] = w_code;
                           w_next_state       = S_SEND_ACK;
                        end
                     end
                  endcase
               end
            end else if (r_timer == TMO_LAST) begin
               w_next_state = S_FAIL;
            end
         end

         S_SEND_ACK: begin
            w_tx_valid = 1'b1;
            w_tx_data  = ACK_CHAR;
            if (tx_ready_i) begin
               if (r_commit) begin
                  w_config_next = r_shadow;
                  w_done_next   = 1'b1;
                  w_commit_next = 1'b0;
                  w_next_state  = S_IDLE;
               end else begin
                  w_timer_next = '0;
                  w_next_state = S_WAIT_CMD;
               end
            end
         end

         S_FAIL: begin
            w_tx_valid = 1'b1;
            w_tx_data  = NAK_CHAR;
            if (tx_ready_i) begin
               w_fail_next   = 1'b1;
               w_shadow_next = r_config;
               w_commit_next = 1'b0;
               w_next_state  = S_IDLE;
            end
         end

         default: w_next_state = S_IDLE;
      endcase
   end

   assign tx_data_o     = w_tx_data;
   assign tx_valid_o    = w_tx_valid;
   assign config_o      = r_config;
   assign config_req_o  = r_req;
   assign config_done_o = r_done;
   assign config_fail_o = r_fail;
   assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_config_negotiator.sv
module tb_uart_config_negotiator;

   localparam int unsigned CLK_HZ = 10_000;
   localparam int unsigned TMO    = 1;
   localparam int unsigned LIMIT  = 10;   // 1 ms at 10 kHz
   localparam logic [7:0]  SYN    = 8'h16;
   localparam logic [7:0]  ACK    = 8'h06;
   localparam logic [7:0]  NAK    = 8'h15;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data_o;
   logic       tx_valid_o;
   logic       tx_ready;
   logic [5:0] config_o;
   logic       config_req_o, config_done_o, config_fail_o, busy_o;

   int n_tests = 0;
   int n_fail  = 0;
   int n_req = 0, n_done = 0, n_flt = 0;
   int exp_req = 0, exp_done = 0, exp_flt = 0;
   logic prev_req = 1'b0, prev_done = 1'b0, prev_flt = 1'b0;
   logic [7:0] sb_q[$];

   uart_config_negotiator #(
      .SYSTEM_CLOCK_FREQ(CLK_HZ),
      .SYN_NUMBER(3),
      .SYN_CHAR(8'h16),
      .ACK_CHAR(8'h06),
      .NAK_CHAR(8'h15),
      .TIMEOUT_MS(TMO),
      .STD_CONFIGURATION(6'b00_00_11)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .rx_data_i(rx_data),
      .rx_valid_i(rx_valid),
      .tx_data_o(tx_data_o),
      .tx_valid_o(tx_valid_o),
      .tx_ready_i(tx_ready),
      .config_o(config_o),
      .config_req_o(config_req_o),
      .config_done_o(config_done_o),
      .config_fail_o(config_fail_o),
      .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: scoreboard pop on each TX handshake, pulse bookkeeping.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_valid_o && tx_ready) begin
            if (sb_q.size() == 0) chk("tx_spurious", 32'(tx_data_o), 32'h100);
            else chk("tx_byte", 32'(tx_data_o), 32'(sb_q.pop_front()));
         end
         if (config_done_o && config_fail_o) chk("done_fail_excl", 32'(config_fail_o), 32'd0);
         if (config_req_o && prev_req)   chk("req_width", 32'(prev_req) + 32'(config_req_o), 32'd1);
         if (config_done_o && prev_done) chk("done_width", 32'(prev_done) + 32'(config_done_o), 32'd1);
         if (config_fail_o && prev_flt)  chk("fail_width", 32'(prev_flt) + 32'(config_fail_o), 32'd1);
         if (config_req_o)  n_req++;
         if (config_done_o) n_done++;
         if (config_fail_o) n_flt++;
      end
      prev_req  = config_req_o;
      prev_done = config_done_o;
      prev_flt  = config_fail_o;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called and returns at posedge+1; the byte is captured on the next edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step(1);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic open_session();
      send_byte(SYN);
      send_byte(SYN);
      send_byte(SYN);
      exp_req++;
      chk("req_pulse", 32'(config_req_o), 32'd1);
      chk("busy_open", 32'(busy_o), 32'd1);
   endtask

   task automatic send_cmd(input logic [7:0] b, input logic [7:0] reply);
      int n;
      sb_q.push_back(reply);
      send_byte(b);
      chk("tx_latency", 32'(tx_valid_o), 32'd1);
      n = 0;
      while (tx_valid_o && n < 20) begin
         step(1);
         n++;
      end
      if (n >= 20) chk("tx_hang", 32'(tx_valid_o), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b1;
      step(3);
      chk("rst_config", 32'(config_o), 32'h03);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_txv", 32'(tx_valid_o), 32'd0);
      rst = 1'b0;
      step(2);

      // Basic session open, closed with end-config (commits unchanged shadow).
      open_session();
      step(1);
      chk("req_single", 32'(config_req_o), 32'd0);
      send_cmd(8'h00, ACK);
      exp_done++;
      chk("done_noop", 32'(config_done_o), 32'd1);
      chk("cfg_noop", 32'(config_o), 32'h03);
      chk("busy_idle", 32'(busy_o), 32'd0);

      // Broken SYN run: leaves syn_cnt at 1, so two more SYNs open a session.
      send_byte(SYN);
      send_byte(SYN);
      send_byte(8'h41);
      send_byte(SYN);
      step(2);
      chk("syn_broken_busy", 32'(busy_o), 32'd0);
      chk("syn_broken_req", 32'(n_req), 32'(exp_req));
      send_byte(SYN);
      send_byte(SYN);
      exp_req++;
      chk("syn_resume_req", 32'(config_req_o), 32'd1);
      send_cmd(8'h00, ACK);
      exp_done++;

      // Reserved stop code -> NAK.
      open_session();
      send_cmd(8'h0E, NAK);
      exp_flt++;
      chk("nak_fail_pulse", 32'(config_fail_o), 32'd1);
      chk("nak_cfg", 32'(config_o), 32'h03);
      chk("nak_busy", 32'(busy_o), 32'd0);

      // Timeout: a byte on the last timer cycle still wins; silence then fails.
      open_session();
      send_cmd(8'h04, ACK);
      step(LIMIT - 1);
      send_cmd(8'h08, ACK);
      step(LIMIT - 1);
      chk("no_early_timeout", 32'(tx_valid_o), 32'd0);
      sb_q.push_back(NAK);
      step(1);
      chk("timeout_nak_valid", 32'(tx_valid_o), 32'd1);
      step(1);
      exp_flt++;
      chk("timeout_fail_pulse", 32'(config_fail_o), 32'd1);
      chk("timeout_cfg", 32'(config_o), 32'h03);
      chk("timeout_busy", 32'(busy_o), 32'd0);
      // Shadow must have been discarded: an empty session commits 6'h03.
      open_session();
      send_cmd(8'h00, ACK);
      exp_done++;
      chk("shadow_discard", 32'(config_o), 32'h03);

      // Full configuration commit.
      open_session();
      send_cmd(8'h04, ACK);
      send_cmd(8'h09, ACK);
      send_cmd(8'h0D, ACK);
      chk("no_early_commit", 32'(config_o), 32'h03);
      send_cmd(8'h00, ACK);
      exp_done++;
      chk("commit_pulse", 32'(config_done_o), 32'd1);
      chk("commit_cfg", 32'(config_o), 32'b01_01_00);
      step(1);
      chk("commit_pulse_end", 32'(config_done_o), 32'd0);

      // Back-pressure: ACK held, end-config byte during SEND_ACK dropped.
      open_session();
      tx_ready = 1'b0;
      sb_q.push_back(ACK);
      send_byte(8'h0C);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) send_byte(8'h00);
         else step(1);
         chk("stall_valid", 32'(tx_valid_o), 32'd1);
         chk("stall_data", 32'(tx_data_o), 32'(ACK));
      end
      tx_ready = 1'b1;
      step(1);
      chk("stall_release", 32'(tx_valid_o), 32'd0);
      step(3);
      chk("stall_no_commit", 32'(config_o), 32'b01_01_00);
      chk("stall_busy", 32'(busy_o), 32'd1);

      // Asynchronous reset mid-session.
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_cfg", 32'(config_o), 32'h03);
      chk("midrst_busy", 32'(busy_o), 32'd0);
      step(2);
      rst = 1'b0;
      step(2);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      chk("req_count", 32'(n_req), 32'(exp_req));
      chk("done_count", 32'(n_done), 32'(exp_done));
      chk("fail_count", 32'(n_flt), 32'(exp_flt));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
